uio_bus_arbiter: RTL and testbench
==================================

Name: uio_bus_arbiter

Overview:
- Shares the 8-bit bidirectional uio pad bus (uio_in / uio_out / uio_oe) between NUM_REQ internal requesters of the tt_um top.
- Requesters issue bursts; grants rotate round-robin.
- Inserts bus turnaround cycles (uio_oe = 0) on every direction change, so pad drive never overlaps with external drive.
- Gated by the top-level ena.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TURN_CYC, 1, idle cycles with uio_oe = 0 on direction change (1..3)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ena  in  1  design enable; low blocks grants and aborts bursts
req  in  NUM_REQ  per-requester burst request, level
req_dir  in  NUM_REQ  1 = drive pads (write), 0 = sample pads (read)
req_len  in  NUM_REQ*4  burst length minus 1 (0..15 gives 1..16 beats); slice i = bits [4i+3:4i]
req_wdata  in  NUM_REQ*8  write data per requester for the current beat; slice i = bits [8i+7:8i]
uio_in  in  8  pad input path
gnt  out  NUM_REQ  one-hot grant, registered
beat  out  1  a beat transfers this cycle
last  out  1  final beat of the burst
rdata  out  8  equals uio_in; valid when beat=1 and the burst is a read
busy  out  1  state != IDLE
uio_out  out  8  pad output path
uio_oe  out  8  pad enable; all-ones or all-zero

Behaviour:
- Reset is synchronous and active-high. Reset values:
  - state = IDLE, gnt = 0, beat = 0, last = 0, busy = 0.
  - uio_oe = 0, uio_out = 0, bus_dir = 0 (input).
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-burst behaves identically and no further beats are produced.
- States are IDLE, TURN and XFER.
- IDLE:
  - req, req_dir and req_len are sampled here only.
  - If ena=1 and req != 0, the winner is the first set req bit searching upward from rr_ptr+1, with wrap.
  - On a win, the next edge latches: winner index, dir, len into beat counter cnt, gnt = onehot(winner), and rr_ptr = winner.
  - Next state is XFER if dir == bus_dir, otherwise TURN.
- TURN:
  - uio_oe = 0 and the turn counter runs for TURN_CYC cycles.
  - On exit, bus_dir = latched dir and the state goes to XFER.
  - gnt is held throughout; beat = 0.
- XFER:
  - beat = 1 every cycle; last = (cnt == 0); cnt decrements each beat.
  - Write: uio_out = req_wdata slice of the winner (combinational), and the hold register captures that value each beat.
  - Read: rdata = uio_in, and the requester samples it when beat=1.
  - After the last beat the next state is IDLE and gnt = 0. There is at least one IDLE cycle between bursts.
  - A burst of len L produces exactly L+1 beats, and the grant-to-first-beat latency is 1 cycle (same direction) or 1+TURN_CYC cycles.
- uio_oe:
  - 8'hFF when bus_dir = 1 and state != TURN, otherwise 8'h00.
  - In IDLE after a write, the pads stay driven with the hold register value.
- uio_out equals the hold register whenever the state is not a write XFER.
- Dropping req mid-burst is ignored; the burst completes. Changing req_dir or req_len mid-burst has no effect.
- ena dropping in TURN or XFER:
  - On the next edge: state = IDLE, gnt = 0, bus_dir = 0, uio_oe = 0.
  - last is never asserted for the aborted burst, and rr_ptr keeps the aborted winner.
- Simultaneous requests are resolved by the round-robin order only. No requester is starved: with all requesting, each wins once per NUM_REQ bursts.
- gnt is always one-hot or zero, and uio_oe is never nonzero in TURN.

Test Plan:
- Reset, then req=4'b0001, dir=1, len=2, wdata0=8'hA5:
  - gnt=0001 the next cycle; TURN for 1 cycle with uio_oe=00.
  - 3 beats with uio_out=A5 and uio_oe=FF; last on the 3rd beat.
  - IDLE after, with uio_oe still FF.
- Read after that write: req1, dir=0, len=0, uio_in=8'h3C:
  - TURN cycle with uio_oe=00, then 1 beat with rdata=3C and last=1.
  - uio_oe stays 00 afterwards.
- All four requesting continuously with len=0 and the same dir:
  - Grant order 0,1,2,3,0 with one IDLE cycle between each.
- ena dropped on the 2nd beat of a len=5 write:
  - The next cycle is IDLE with gnt=0 and uio_oe=00; no last.
  - The next grant goes to the following requester.
- rst asserted during TURN: the next cycle shows all outputs at reset values, and requester 0 wins the next arbitration.
- req deasserted after grant, len=3: 4 beats are still produced and last is on the 4th.

Source files
------------

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: shares the bidirectional uio pad bus between NUM_REQ
// burst requesters. Grants rotate round-robin, and idle turnaround cycles
// with the pads released are inserted whenever the bus direction flips.
module uio_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int TURN_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_dir,
  input  logic [NUM_REQ*4-1:0]   req_len,
  input  logic [NUM_REQ*8-1:0]   req_wdata,
  input  logic [7:0]             uio_in,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   beat,
  output logic                   last,
  output logic [7:0]             rdata,
  output logic                   busy,
  output logic [7:0]             uio_out,
  output logic [7:0]             uio_oe
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] TURN_LOAD = 2'(TURN_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               dir_q, dir_d;
  logic               bus_dir_q, bus_dir_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         turn_q, turn_d;
  logic [7:0]         hold_q, hold_d;

  // Per-requester views of the packed length and write-data buses.
  logic [3:0] len_arr   [NUM_REQ];
  logic [7:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign len_arr[gi]   = req_len[4*gi +: 4];
    assign wdata_arr[gi] = req_wdata[8*gi +: 8];
  end

  // Round-robin search: first set req bit above rr_ptr, wrapping around.
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   cand;
  logic [IW-1:0] cand_idx;

  // Pick the winner among the currently asserted requests.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      cand_idx = cand[IW-1:0];
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state logic: arbitration in IDLE, turnaround timing, beat counting.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    dir_d     = dir_q;
    bus_dir_d = bus_dir_q;
    cnt_d     = cnt_q;
    turn_d    = turn_q;
    hold_d    = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (ena && win_found) begin
          idx_d          = win_idx;
          rr_ptr_d       = win_idx;
          dir_d          = req_dir[win_idx];
          cnt_d          = len_arr[win_idx];
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          turn_d         = TURN_LOAD;
          state_d        = (req_dir[win_idx] == bus_dir_q) ? ST_XFER : ST_TURN;
        end
      end
      ST_TURN: begin
        if (turn_q == '0) begin
          bus_dir_d = dir_q;
          state_d   = ST_XFER;
        end else begin
          turn_d = turn_q - 2'd1;
        end
      end
      ST_XFER: begin
        if (dir_q) begin
          hold_d = wdata_arr[idx_q];
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    // Losing ena aborts whatever is in flight and releases the pads.
    if (!ena && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      gnt_d     = '0;
      bus_dir_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      rr_ptr_q  <= IW'(NUM_REQ - 1);
      dir_q     <= 1'b0;
      bus_dir_q <= 1'b0;
      cnt_q     <= '0;
      turn_q    <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      dir_q     <= dir_d;
      bus_dir_q <= bus_dir_d;
      cnt_q     <= cnt_d;
      turn_q    <= turn_d;
      hold_q    <= hold_d;
    end
  end

  // Output decode: pads drive only in write direction and never in TURN.
  always_comb begin
    gnt     = gnt_q;
    beat    = (state_q == ST_XFER);
    last    = (state_q == ST_XFER) && (cnt_q == '0);
    busy    = (state_q != ST_IDLE);
    rdata   = uio_in;
    uio_oe  = (bus_dir_q && state_q != ST_TURN) ? 8'hFF : 8'h00;
    uio_out = (state_q == ST_XFER && dir_q) ? wdata_arr[idx_q] : hold_q;
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: a burst-schedule model checked every cycle,
// plus directed literal expectations for the main scenarios.
module tb_uio_bus_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int TURN_CYC = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               ena;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_dir;
  logic [NUM_REQ*4-1:0] req_len;
  logic [NUM_REQ*8-1:0] req_wdata;
  logic [7:0]         uio_in;
  logic [NUM_REQ-1:0] gnt;
  logic               beat;
  logic               last;
  logic [7:0]         rdata;
  logic               busy;
  logic [7:0]         uio_out;
  logic [7:0]         uio_oe;

  uio_bus_arbiter #(.NUM_REQ(NUM_REQ), .TURN_CYC(TURN_CYC)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .req_dir(req_dir),
    .req_len(req_len), .req_wdata(req_wdata), .uio_in(uio_in),
    .gnt(gnt), .beat(beat), .last(last), .rdata(rdata), .busy(busy),
    .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each granted burst becomes a list of future cycles
  // (TURN_CYC turnaround slots if the direction flips, then len+1 beats).
  typedef struct packed { logic turn; logic last; } slot_t;
  slot_t m_q[$];
  int    m_rr      = NUM_REQ - 1;
  int    m_win     = 0;
  logic  m_dir     = 1'b0;
  logic  m_bus_dir = 1'b0;
  logic [7:0] m_hold = 8'h00;

  function automatic logic [7:0] wdata_of(input int i);
    return req_wdata[8*i +: 8];
  endfunction

  // Model advance on each rising edge, using the inputs seen at that edge.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_bus_dir = 1'b0;
      m_hold    = 8'h00;
      m_rr      = NUM_REQ - 1;
    end else if (m_q.size() != 0) begin
      if (!m_q[0].turn && m_dir) m_hold = wdata_of(m_win);
      if (!ena) begin
        m_q.delete();
        m_bus_dir = 1'b0;
      end else begin
        void'(m_q.pop_front());
        m_bus_dir = m_dir;
      end
    end else if (ena && req != '0) begin
      int w;
      int len;
      w = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_rr + k) % NUM_REQ;
        if (w < 0 && req[c]) w = c;
      end
      m_win = w;
      m_rr  = w;
      m_dir = req_dir[w];
      len   = int'(req_len[4*w +: 4]);
      if (m_dir != m_bus_dir) begin
        for (int t = 0; t < TURN_CYC; t++) m_q.push_back('{turn: 1'b1, last: 1'b0});
      end
      for (int b = 0; b <= len; b++) m_q.push_back('{turn: 1'b0, last: (b == len)});
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic [NUM_REQ-1:0] eg;
      logic eb, el, ebusy;
      logic [7:0] eoe, eout;
      eg = '0;
      if (m_q.size() == 0) begin
        eb = 1'b0; el = 1'b0; ebusy = 1'b0;
        eoe  = m_bus_dir ? 8'hFF : 8'h00;
        eout = m_hold;
      end else if (m_q[0].turn) begin
        eg[m_win] = 1'b1;
        eb = 1'b0; el = 1'b0; ebusy = 1'b1;
        eoe = 8'h00; eout = m_hold;
      end else begin
        eg[m_win] = 1'b1;
        eb = 1'b1; el = m_q[0].last; ebusy = 1'b1;
        eoe  = m_dir ? 8'hFF : 8'h00;
        eout = m_dir ? wdata_of(m_win) : m_hold;
        if (!m_dir) chk("m_rdata", 32'(rdata), 32'(uio_in));
      end
      chk("m_gnt", 32'(gnt), 32'(eg));
      chk("m_beat", 32'(beat), 32'(eb));
      chk("m_last", 32'(last), 32'(el));
      chk("m_busy", 32'(busy), 32'(ebusy));
      chk("m_oe", 32'(uio_oe), 32'(eoe));
      chk("m_out", 32'(uio_out), 32'(eout));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int nb;
  int lastpos;

  initial begin
    rst = 1'b1; ena = 1'b1; req = '0; req_dir = '0; req_len = '0;
    req_wdata = '0; uio_in = 8'h00;
    cyc(); cyc();
    rst = 1'b0; chk_en = 1'b1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_oe", 32'(uio_oe), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_out", 32'(uio_out), 32'h0);

    // Write burst from requester 0, 3 beats of A5.
    $display("txn: write req0 len=2 data=A5");
    req = 4'b0001; req_dir = 4'b0001; req_len[3:0] = 4'd2; req_wdata[7:0] = 8'hA5;
    cyc();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_turn_oe", 32'(uio_oe), 32'h0);
    chk("t1_turn_beat", 32'(beat), 32'h0);
    req = '0;
    for (int b = 0; b < 3; b++) begin
      cyc();
      chk("t1_beat", 32'(beat), 32'h1);
      chk("t1_out", 32'(uio_out), 32'hA5);
      chk("t1_oe", 32'(uio_oe), 32'hFF);
      chk("t1_last", 32'(last), 32'(b == 2));
    end
    cyc();
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_idle_oe", 32'(uio_oe), 32'hFF);
    chk("t1_idle_out", 32'(uio_out), 32'hA5);

    // Read burst from requester 1 right after the write.
    $display("txn: read req1 len=0 uio_in=3C");
    req = 4'b0010; req_dir = 4'b0000; req_len[7:4] = 4'd0; uio_in = 8'h3C;
    cyc();
    chk("t2_gnt", 32'(gnt), 32'h2);
    chk("t2_turn_oe", 32'(uio_oe), 32'h0);
    chk("t2_turn_beat", 32'(beat), 32'h0);
    req = '0;
    cyc();
    chk("t2_beat", 32'(beat), 32'h1);
    chk("t2_last", 32'(last), 32'h1);
    chk("t2_rdata", 32'(rdata), 32'h3C);
    chk("t2_oe", 32'(uio_oe), 32'h0);
    cyc();
    chk("t2_idle_oe", 32'(uio_oe), 32'h0);

    // All four requesting with len=0: rotation 0,1,2,3,0.
    $display("txn: reset then all requesters, len=0 reads");
    rst = 1'b1;
    cyc();
    rst = 1'b0; req = 4'hF; req_dir = '0; req_len = '0;
    for (int i = 1; i <= 10; i++) begin
      logic [3:0] eg;
      cyc();
      eg = '0;
      if (i % 2 == 1) eg[exp_order[(i-1)/2]] = 1'b1;
      chk("t3_rr_gnt", 32'(gnt), 32'(eg));
      if (i == 9) req = '0;
    end

    // ena dropped on the second beat of a len=5 write from requester 1.
    $display("txn: write req1 len=5, ena drop on beat 2");
    req = 4'b0010; req_dir = 4'b0010; req_len[7:4] = 4'd5; req_wdata[15:8] = 8'h5A;
    cyc();
    chk("t4_gnt", 32'(gnt), 32'h2);
    req = '0;
    cyc();
    chk("t4_b1_last", 32'(last), 32'h0);
    cyc();
    chk("t4_b2_beat", 32'(beat), 32'h1);
    ena = 1'b0;
    cyc();
    chk("t4_abort_gnt", 32'(gnt), 32'h0);
    chk("t4_abort_oe", 32'(uio_oe), 32'h0);
    chk("t4_abort_busy", 32'(busy), 32'h0);
    chk("t4_abort_last", 32'(last), 32'h0);
    ena = 1'b1; req = 4'hF; req_dir = '0; req_len = '0;
    cyc();
    chk("t4_next_gnt", 32'(gnt), 32'h4);
    req = '0;
    cyc();

    // Reset asserted while requester 2 is in TURN.
    $display("txn: write req2 len=1, reset during turn");
    req = 4'b0100; req_dir = 4'b0100; req_len[11:8] = 4'd1; req_wdata[23:16] = 8'hC3;
    cyc();
    chk("t5_turn_gnt", 32'(gnt), 32'h4);
    chk("t5_turn_oe", 32'(uio_oe), 32'h0);
    rst = 1'b1; req = 4'hF; req_dir = '0; req_len = '0;
    cyc();
    chk("t5_rst_gnt", 32'(gnt), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_oe", 32'(uio_oe), 32'h0);
    chk("t5_rst_out", 32'(uio_out), 32'h0);
    chk("t5_rst_beat", 32'(beat), 32'h0);
    rst = 1'b0;
    cyc();
    chk("t5_after_gnt", 32'(gnt), 32'h1);
    req = '0;
    cyc();

    // req3 drops right after grant; len and dir change mid-burst too.
    $display("txn: read req3 len=3, req dropped after grant");
    req = 4'b1000; req_dir = '0; req_len[15:12] = 4'd3;
    cyc();
    chk("t6_gnt", 32'(gnt), 32'h8);
    req = '0; req_len = '0; req_dir = 4'b1000;
    nb = 0; lastpos = 0;
    for (int i = 0; i < 6; i++) begin
      if (beat) begin
        nb++;
        if (last) lastpos = nb;
      end
      cyc();
    end
    chk("t6_beats", 32'(nb), 32'd4);
    chk("t6_lastpos", 32'(lastpos), 32'd4);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
